// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave stream block: FSM encoding,
// SPI mode constants and mode-decoding helpers.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    // mode is {CPOL,CPHA}; data is sampled on the rising edge when they match
    function automatic logic sample_on_rise(input logic [1:0] mode);
        return mode[1] == mode[0];
    endfunction

    function automatic logic cpha(input logic [1:0] mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-stage synchroniser for an asynchronous pin with single-cycle
// rise/fall pulses derived from the last two synchronised samples.
module spi_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_stream.sv
// Parametrised full-duplex SPI slave with oversampled sclk, multi-word frames,
// a one-word transmit holding register and frame start/end/abort markers.
module spi_slave_stream
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter logic [1:0]  MODE        = SPI_MODE0,
    parameter bit          MSB_FIRST   = 1'b1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              frame_start,
    output logic              frame_end,
    output logic              frame_abort,
    output logic              tx_underrun
);

    localparam logic        SAMPLE_RISE = sample_on_rise(MODE);
    localparam logic        CPHA        = cpha(MODE);
    localparam logic        CPOL        = MODE[1];
    localparam int unsigned CNT_W       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_t state, state_next;

    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   mosi_s;

    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] rx_sh, rx_next;
    logic [DATA_W-1:0] tx_sh, tx_shifted, load_word;
    logic [DATA_W-1:0] hold_data;
    logic              hold_full, load_pend;

    logic sample_edge, shift_edge, word_done, tx_accept, load_point, underrun_now;
    logic go_active, start_now, end_now, abort_now;

    spi_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (CPOL)
    ) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (cs_n),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // mosi sits at the same synchroniser depth as sclk, so the two stay aligned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_sync <= '0;
        end else begin
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        go_active  = 1'b0;
        start_now  = 1'b0;
        end_now    = 1'b0;
        abort_now  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next = ACTIVE;
                    go_active  = 1'b1;
                    start_now  = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    end_now    = 1'b1;
                    // a word finishing on this very cycle is complete, not aborted
                    abort_now  = (bit_cnt != '0) && !word_done;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign sample_edge = (state == ACTIVE) && (SAMPLE_RISE ? sclk_rise : sclk_fall);
    assign shift_edge  = (state == ACTIVE) && (SAMPLE_RISE ? sclk_fall : sclk_rise);
    assign word_done   = sample_edge && (bit_cnt == LAST_BIT);

    assign rx_next = MSB_FIRST ? {rx_sh[DATA_W-2:0], mosi_s} : {mosi_s, rx_sh[DATA_W-1:1]};
    assign tx_shifted = MSB_FIRST ? {tx_sh[DATA_W-2:0], 1'b0} : {1'b0, tx_sh[DATA_W-1:1]};

    assign tx_accept  = tx_valid && !hold_full;
    assign load_point = CPHA ? (shift_edge && (bit_cnt == '0))
                             : (go_active || (shift_edge && load_pend));
    // an accept coinciding with a load bypasses the holding register
    assign load_word    = hold_full ? hold_data : (tx_accept ? tx_data : '0);
    assign underrun_now = load_point && !hold_full && !tx_accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt     <= '0;
            rx_sh       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_sh       <= '0;
            hold_data   <= '0;
            hold_full   <= 1'b0;
            load_pend   <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            frame_abort <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_valid    <= word_done;
            frame_start <= start_now;
            frame_end   <= end_now;
            frame_abort <= abort_now;
            tx_underrun <= underrun_now;

            if (state == IDLE) begin
                bit_cnt <= '0;
            end else if (sample_edge) begin
                bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
            end

            if (sample_edge) begin
                rx_sh <= rx_next;
            end
            if (word_done) begin
                rx_data <= rx_next;
            end

            if (state == IDLE) begin
                load_pend <= 1'b0;
            end else if (word_done) begin
                load_pend <= !CPHA;
            end else if (load_point) begin
                load_pend <= 1'b0;
            end

            if (load_point) begin
                tx_sh <= load_word;
            end else if (state == IDLE) begin
                tx_sh <= '0;
            end else if (shift_edge) begin
                tx_sh <= tx_shifted;
            end

            if (load_point) begin
                hold_full <= 1'b0;
            end else if (tx_accept) begin
                hold_full <= 1'b1;
                hold_data <= tx_data;
            end
        end
    end

    assign tx_ready = !hold_full;
    assign miso_oe  = (state == ACTIVE);
    assign miso     = (state == ACTIVE) ? (MSB_FIRST ? tx_sh[DATA_W-1] : tx_sh[0]) : 1'b0;

endmodule

// File: tb/tb_spi_slave_stream.sv
// Self-checking bench: four slave configurations driven by a bit-level SPI
// master model, with rx/tx expectations kept in scoreboard queues.
module tb_spi_slave_stream;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  sclk = 4'b1010;
    logic [3:0]  cs_n = 4'hF;
    logic [3:0]  mosi = 4'h0;
    logic [3:0]  miso, miso_oe, rx_valid, tx_valid, tx_ready;
    logic [3:0]  frame_start, frame_end, frame_abort, tx_underrun;
    logic [15:0] tx_d [4];
    logic [7:0]  rx_d0, rx_d2, rx_d3;
    logic [15:0] rx_d1;

    int checks = 0;
    int errors = 0;
    int cur = 0;
    int n_rx, n_start, n_end, n_abort, n_abort_alone, n_under;
    logic fire;
    logic [15:0] exp_w;
    logic [15:0] tx_q[$];
    logic [15:0] exp_rx[$];
    logic [15:0] exp_miso[$];

    always #5 clk = ~clk;

    spi_slave_stream #(.DATA_W(8), .MODE(2'b00), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u0 (
        .clk(clk), .rst(rst), .sclk(sclk[0]), .cs_n(cs_n[0]), .mosi(mosi[0]),
        .miso(miso[0]), .miso_oe(miso_oe[0]), .rx_data(rx_d0), .rx_valid(rx_valid[0]),
        .tx_data(tx_d[0][7:0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .frame_start(frame_start[0]), .frame_end(frame_end[0]),
        .frame_abort(frame_abort[0]), .tx_underrun(tx_underrun[0]));

    spi_slave_stream #(.DATA_W(16), .MODE(2'b11), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u1 (
        .clk(clk), .rst(rst), .sclk(sclk[1]), .cs_n(cs_n[1]), .mosi(mosi[1]),
        .miso(miso[1]), .miso_oe(miso_oe[1]), .rx_data(rx_d1), .rx_valid(rx_valid[1]),
        .tx_data(tx_d[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
        .frame_start(frame_start[1]), .frame_end(frame_end[1]),
        .frame_abort(frame_abort[1]), .tx_underrun(tx_underrun[1]));

    spi_slave_stream #(.DATA_W(8), .MODE(2'b01), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) u2 (
        .clk(clk), .rst(rst), .sclk(sclk[2]), .cs_n(cs_n[2]), .mosi(mosi[2]),
        .miso(miso[2]), .miso_oe(miso_oe[2]), .rx_data(rx_d2), .rx_valid(rx_valid[2]),
        .tx_data(tx_d[2][7:0]), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
        .frame_start(frame_start[2]), .frame_end(frame_end[2]),
        .frame_abort(frame_abort[2]), .tx_underrun(tx_underrun[2]));

    spi_slave_stream #(.DATA_W(8), .MODE(2'b10), .MSB_FIRST(1'b0), .SYNC_STAGES(3)) u3 (
        .clk(clk), .rst(rst), .sclk(sclk[3]), .cs_n(cs_n[3]), .mosi(mosi[3]),
        .miso(miso[3]), .miso_oe(miso_oe[3]), .rx_data(rx_d3), .rx_valid(rx_valid[3]),
        .tx_data(tx_d[3][7:0]), .tx_valid(tx_valid[3]), .tx_ready(tx_ready[3]),
        .frame_start(frame_start[3]), .frame_end(frame_end[3]),
        .frame_abort(frame_abort[3]), .tx_underrun(tx_underrun[3]));

    function automatic logic [15:0] rxd(input int i);
        case (i)
            0:       return {8'h00, rx_d0};
            1:       return rx_d1;
            2:       return {8'h00, rx_d2};
            default: return {8'h00, rx_d3};
        endcase
    endfunction

    function automatic int w_of(input int i);
        return (i == 1) ? 16 : 8;
    endfunction

    function automatic logic cpol_of(input int i);
        return (i == 1) || (i == 3);
    endfunction

    function automatic logic cpha_of(input int i);
        return (i == 1) || (i == 2);
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        n_rx = 0; n_start = 0; n_end = 0; n_abort = 0; n_abort_alone = 0; n_under = 0;
    endtask

    // master shifts nbits of w and returns what it captured from miso
    task automatic send_word(input int i, input logic [15:0] w, input int nbits,
                             output logic [15:0] got);
        int pos;
        logic cp;
        cp  = cpol_of(i);
        got = '0;
        for (int b = 0; b < nbits; b++) begin
            pos = (i == 3) ? b : (w_of(i) - 1 - b);
            if (!cpha_of(i)) begin
                mosi[i] = w[pos];
                wait_clk(HALF);
                sclk[i] = ~cp;
                got[pos] = miso[i];
                wait_clk(HALF);
                sclk[i] = cp;
            end else begin
                sclk[i] = ~cp;
                mosi[i] = w[pos];
                wait_clk(HALF);
                sclk[i] = cp;
                got[pos] = miso[i];
                wait_clk(HALF);
            end
        end
    endtask

    // transmit feeder: presents the head of tx_q to the selected slave
    initial begin
        tx_valid = '0;
        for (int k = 0; k < 4; k++) tx_d[k] = '0;
        forever begin
            @(negedge clk);
            fire = !rst && tx_valid[cur] && tx_ready[cur];
            @(posedge clk);
            #1;
            if (fire && tx_q.size() > 0) void'(tx_q.pop_front());
            tx_valid = '0;
            if (tx_q.size() > 0) begin
                tx_valid[cur] = 1'b1;
                tx_d[cur] = tx_q[0];
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid[cur]) begin
                n_rx++;
                checks++;
                if (exp_rx.size() == 0) begin
                    errors++;
                    $display("FAIL rx_unexpected: got %h, expected no word", rxd(cur));
                end else begin
                    exp_w = exp_rx.pop_front();
                    if (rxd(cur) !== exp_w) begin
                        errors++;
                        $display("FAIL rx_data: got %h, expected %h", rxd(cur), exp_w);
                    end
                end
            end
            if (tx_underrun[cur]) n_under++;
            if (frame_start[cur]) n_start++;
            if (frame_end[cur]) n_end++;
            if (frame_abort[cur]) n_abort++;
            if (frame_abort[cur] && !frame_end[cur]) n_abort_alone++;
        end
    end

    task automatic test_reset();
        wait_clk(3);
        checks++;
        if (miso !== 4'h0 || miso_oe !== 4'h0) begin
            errors++; $display("FAIL reset_miso: got %b/%b, expected 0000/0000", miso, miso_oe);
        end
        checks++;
        if (tx_ready !== 4'hF || rx_valid !== 4'h0) begin
            errors++; $display("FAIL reset_ready_valid: got %b/%b, expected 1111/0000", tx_ready, rx_valid);
        end
        checks++;
        if ((frame_start | frame_end | frame_abort | tx_underrun) !== 4'h0) begin
            errors++; $display("FAIL reset_pulses: got %b, expected 0000",
                               frame_start | frame_end | frame_abort | tx_underrun);
        end
        checks++;
        if (rx_d0 !== 8'h00 || rx_d1 !== 16'h0000) begin
            errors++; $display("FAIL reset_rx_data: got %h/%h, expected 00/0000", rx_d0, rx_d1);
        end
        rst = 1'b0;
        wait_clk(10);
    endtask

    task automatic test_basic_mode0();
        logic [15:0] got;
        cur = 0;
        clr_counts();
        tx_q.push_back(16'h003C);
        exp_miso.push_back(16'h003C);
        wait_clk(10);
        exp_rx.push_back(16'h00A5);
        cs_n[0] = 1'b0;
        wait_clk(HALF);
        send_word(0, 16'h00A5, 8, got);
        wait_clk(HALF);
        cs_n[0] = 1'b1;
        wait_clk(20);
        exp_w = exp_miso.pop_front();
        checks++;
        if (got !== exp_w) begin errors++; $display("FAIL m0_miso: got %h, expected %h", got, exp_w); end
        checks++;
        if (n_rx !== 1 || exp_rx.size() !== 0) begin
            errors++; $display("FAIL m0_rx_count: got %0d, expected 1", n_rx);
        end
        checks++;
        if (n_start !== 1 || n_end !== 1 || n_abort !== 0) begin
            errors++; $display("FAIL m0_frame: got start %0d end %0d abort %0d, expected 1 1 0",
                               n_start, n_end, n_abort);
        end
        // the trailing shift edge after the last word is a load point with nothing queued
        checks++;
        if (n_under !== 1) begin errors++; $display("FAIL m0_underrun: got %0d, expected 1", n_under); end
        checks++;
        if (miso_oe[0] !== 1'b0) begin errors++; $display("FAIL m0_oe_idle: got %b, expected 0", miso_oe[0]); end
    endtask

    task automatic test_multiword_mode3();
        logic [15:0] got;
        logic [15:0] mw [3] = '{16'h1234, 16'hABCD, 16'h0F0F};
        logic [15:0] tw [3] = '{16'h1111, 16'h2222, 16'h3333};
        cur = 1;
        clr_counts();
        for (int k = 0; k < 3; k++) begin
            tx_q.push_back(tw[k]);
            exp_miso.push_back(tw[k]);
            exp_rx.push_back(mw[k]);
        end
        wait_clk(10);
        cs_n[1] = 1'b0;
        wait_clk(HALF);
        for (int k = 0; k < 3; k++) begin
            send_word(1, mw[k], 16, got);
            exp_w = exp_miso.pop_front();
            checks++;
            if (got !== exp_w) begin errors++; $display("FAIL m3_miso_w%0d: got %h, expected %h", k, got, exp_w); end
        end
        wait_clk(HALF);
        cs_n[1] = 1'b1;
        wait_clk(20);
        checks++;
        if (n_rx !== 3 || exp_rx.size() !== 0) begin
            errors++; $display("FAIL m3_rx_count: got %0d, expected 3", n_rx);
        end
        checks++;
        if (n_under !== 0) begin errors++; $display("FAIL m3_underrun: got %0d, expected 0", n_under); end
        checks++;
        if (n_start !== 1 || n_end !== 1 || n_abort !== 0) begin
            errors++; $display("FAIL m3_frame: got start %0d end %0d abort %0d, expected 1 1 0",
                               n_start, n_end, n_abort);
        end
    endtask

    task automatic test_underrun_mode1();
        logic [15:0] got;
        cur = 2;
        clr_counts();
        tx_q.push_back(16'h005A);
        exp_miso.push_back(16'h005A);
        exp_miso.push_back(16'h0000);
        exp_rx.push_back(16'h00C3);
        exp_rx.push_back(16'h007E);
        wait_clk(10);
        cs_n[2] = 1'b0;
        wait_clk(HALF);
        send_word(2, 16'h00C3, 8, got);
        exp_w = exp_miso.pop_front();
        checks++;
        if (got !== exp_w) begin errors++; $display("FAIL m1_miso_w0: got %h, expected %h", got, exp_w); end
        send_word(2, 16'h007E, 8, got);
        exp_w = exp_miso.pop_front();
        checks++;
        if (got !== exp_w) begin errors++; $display("FAIL m1_miso_w1: got %h, expected %h", got, exp_w); end
        wait_clk(HALF);
        cs_n[2] = 1'b1;
        wait_clk(20);
        checks++;
        if (n_under !== 1) begin errors++; $display("FAIL m1_underrun: got %0d, expected 1", n_under); end
        checks++;
        if (n_rx !== 2 || exp_rx.size() !== 0) begin
            errors++; $display("FAIL m1_rx_count: got %0d, expected 2", n_rx);
        end
    endtask

    // cs_n rises on the same sclk edge that completes the word
    task automatic test_simultaneous_end();
        logic [15:0] got;
        cur = 2;
        clr_counts();
        exp_rx.push_back(16'h0096);
        cs_n[2] = 1'b0;
        wait_clk(HALF);
        send_word(2, 16'h0096, 7, got);
        sclk[2] = 1'b1;
        mosi[2] = 1'b0;
        wait_clk(HALF);
        sclk[2] = 1'b0;
        cs_n[2] = 1'b1;
        wait_clk(20);
        checks++;
        if (n_rx !== 1 || exp_rx.size() !== 0) begin
            errors++; $display("FAIL simul_rx_count: got %0d, expected 1", n_rx);
        end
        checks++;
        if (n_end !== 1 || n_abort !== 0) begin
            errors++; $display("FAIL simul_frame: got end %0d abort %0d, expected 1 0", n_end, n_abort);
        end
    endtask

    task automatic test_lsb_mode2();
        logic [15:0] got;
        cur = 3;
        clr_counts();
        tx_q.push_back(16'h0080);
        exp_miso.push_back(16'h0080);
        exp_rx.push_back(16'h0001);
        wait_clk(10);
        cs_n[3] = 1'b0;
        wait_clk(HALF);
        send_word(3, 16'h0001, 8, got);
        wait_clk(HALF);
        cs_n[3] = 1'b1;
        wait_clk(20);
        exp_w = exp_miso.pop_front();
        checks++;
        if (got !== exp_w) begin errors++; $display("FAIL lsb_miso: got %h, expected %h", got, exp_w); end
        checks++;
        if (got[0] !== 1'b0 || got[7] !== 1'b1) begin
            errors++; $display("FAIL lsb_first_last: got first %b last %b, expected 0 1", got[0], got[7]);
        end
        checks++;
        if (n_rx !== 1 || exp_rx.size() !== 0) begin
            errors++; $display("FAIL lsb_rx_count: got %0d, expected 1", n_rx);
        end
        checks++;
        if (n_under !== 1) begin errors++; $display("FAIL lsb_underrun: got %0d, expected 1", n_under); end
    endtask

    task automatic test_abort();
        logic [15:0] got;
        cur = 0;
        clr_counts();
        cs_n[0] = 1'b0;
        wait_clk(HALF);
        send_word(0, 16'h00FF, 5, got);
        wait_clk(HALF);
        cs_n[0] = 1'b1;
        wait_clk(20);
        checks++;
        if (n_end !== 1 || n_abort !== 1 || n_abort_alone !== 0) begin
            errors++; $display("FAIL abort_pulses: got end %0d abort %0d lone %0d, expected 1 1 0",
                               n_end, n_abort, n_abort_alone);
        end
        checks++;
        if (n_rx !== 0) begin errors++; $display("FAIL abort_rx_valid: got %0d, expected 0", n_rx); end
        checks++;
        if (rx_d0 !== 8'hA5) begin errors++; $display("FAIL abort_rx_hold: got %h, expected a5", rx_d0); end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] got;
        cur = 0;
        clr_counts();
        cs_n[0] = 1'b0;
        wait_clk(HALF);
        tx_q.push_back(16'h0099);
        for (int k = 0; k < 20 && tx_ready[0]; k++) wait_clk(1);
        checks++;
        if (tx_ready[0] !== 1'b0) begin errors++; $display("FAIL rst_hold_full: got %b, expected 0", tx_ready[0]); end
        send_word(0, 16'h00E0, 3, got);
        rst = 1'b1;
        wait_clk(3);
        checks++;
        if (miso_oe[0] !== 1'b0 || miso[0] !== 1'b0 || tx_ready[0] !== 1'b1) begin
            errors++; $display("FAIL rst_outputs: got oe %b miso %b ready %b, expected 0 0 1",
                               miso_oe[0], miso[0], tx_ready[0]);
        end
        checks++;
        if (rx_d0 !== 8'h00 || rx_valid[0] !== 1'b0) begin
            errors++; $display("FAIL rst_rx: got %h valid %b, expected 00 0", rx_d0, rx_valid[0]);
        end
        rst = 1'b0;
        clr_counts();
        exp_rx.push_back(16'h006B);
        wait_clk(HALF);
        send_word(0, 16'h006B, 8, got);
        wait_clk(HALF);
        cs_n[0] = 1'b1;
        wait_clk(20);
        checks++;
        if (n_start !== 1 || n_end !== 1 || n_abort !== 0) begin
            errors++; $display("FAIL rst_reentry: got start %0d end %0d abort %0d, expected 1 1 0",
                               n_start, n_end, n_abort);
        end
        checks++;
        if (n_rx !== 1 || exp_rx.size() !== 0) begin
            errors++; $display("FAIL rst_rx_count: got %0d, expected 1", n_rx);
        end
    endtask

    initial begin
        clr_counts();
        test_reset();
        test_basic_mode0();
        test_multiword_mode3();
        test_underrun_mode1();
        test_simultaneous_end();
        test_lsb_mode2();
        test_abort();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
